// File: rtl/bram_stream_reader_pkg.sv
// Shared definitions for the BRAM stream reader: FSM states and default sizing.
package bram_stream_reader_pkg;

  localparam int unsigned DefAddrWidth = 12;
  localparam int unsigned DefFifoDepth = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
  } state_e;

endpackage

// File: rtl/stream_fifo.sv
// Synchronous FIFO with flush. Push and pop may happen together at any occupancy,
// including full. rdata reads as zero whenever the FIFO is empty.
module stream_fifo
  import bram_stream_reader_pkg::*;
#(
  parameter int unsigned DEPTH = DefFifoDepth,
  parameter int unsigned WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CntW'(DEPTH));
  assign count   = cnt_q;
  assign rdata   = empty ? '0 : mem_q[rptr_q];
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is fine when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  // Storage, pointers and occupancy; flush empties the FIFO in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= wdata;
        wptr_q        <= wptr_q + PtrW'(1);
      end
      if (do_pop) rptr_q <= rptr_q + PtrW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/bram_stream_reader.sv
// Reads a burst of 32-bit words from a BRAM port and streams them out through a
// small FIFO with valid/ready handshaking.
// Optional feature macro: BRAM_STREAM_STALL_CNT_EN enables the back-pressure
// cycle counter on stall_cnt; without it stall_cnt is tied to zero.
module bram_stream_reader
  import bram_stream_reader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned FIFO_DEPTH = DefFifoDepth
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  bram_clken,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [3:0]            bram_we,
  input  logic [31:0]           bram_data_out,
  output logic [31:0]           out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [15:0]           stall_cnt
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   remain_q, remain_d;
  logic                  inflight_q, inflight_d;
  logic                  done_q, done_d;

  logic                  issue, push, pop, flush, room;
  logic                  fifo_full, fifo_empty;
  logic [CntW-1:0]       fifo_count, occupancy;

  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign bram_clken = issue;
  assign bram_we   = 4'b0000;
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  // Abort throws away both the buffered words and the word returning this cycle.
  assign flush     = abort && busy;
  assign push      = inflight_q && !flush;
  // Slots already committed: buffered words plus the read whose data lands next edge.
  assign occupancy = fifo_count + CntW'(inflight_q);
  assign room      = !fifo_full && (occupancy < CntW'(FIFO_DEPTH));

  // Next-state, read issue and address sequencing. The first read goes out in the
  // start cycle itself so the first word is visible two cycles after start.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    remain_d   = remain_q;
    done_d     = 1'b0;
    issue      = 1'b0;
    bram_addr  = addr_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (abort || (length == '0)) begin
            done_d = 1'b1;
          end else begin
            issue     = 1'b1;
            bram_addr = base_addr;
            addr_d    = base_addr + ADDR_WIDTH'(1);
            remain_d  = length - (ADDR_WIDTH + 1)'(1);
            state_d   = StRun;
          end
        end
      end
      StRun: begin
        if (abort) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else if (remain_q == '0) begin
          state_d = StDrain;
        end else if (room) begin
          issue    = 1'b1;
          addr_d   = addr_q + ADDR_WIDTH'(1);
          remain_d = remain_q - (ADDR_WIDTH + 1)'(1);
          if (remain_q == (ADDR_WIDTH + 1)'(1)) state_d = StDrain;
        end
      end
      StDrain: begin
        if (abort) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else if (!inflight_q &&
                     (fifo_empty || ((fifo_count == CntW'(1)) && pop))) begin
          // Leave as the last word is taken so done lines up with the final accept.
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    inflight_d = issue;
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      remain_q   <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      inflight_q <= inflight_d;
      done_q     <= done_d;
    end
  end

  stream_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .wdata (bram_data_out),
    .pop   (pop),
    .rdata (out_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

`ifdef BRAM_STREAM_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  // Count cycles where a word waits on the consumer; saturates, cleared per burst.
  always_comb begin
    stall_d = stall_q;
    if ((state_q == StIdle) && start) begin
      stall_d = '0;
    end else if (out_valid && !out_ready && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_bram_stream_reader.sv
// Self-checking bench for bram_stream_reader with a behavioural burst model.
module tb_bram_stream_reader;

  localparam int AW    = 12;
  localparam int DEPTH = 4;
  localparam int NWORD = 4096;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          out_ready = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic          busy, done, bram_clken, out_valid;
  logic [AW-1:0] bram_addr;
  logic [3:0]    bram_we;
  logic [31:0]   bram_data_out, out_data;
  logic [15:0]   stall_cnt;

  logic [31:0]   mem [NWORD];

  int errors = 0;
  int checks = 0;

  // Observations and model state
  int          cyc = 0;
  logic [31:0] got[$];
  int          addrs[$];
  int done_cnt, done_cyc, first_valid_cyc, first_acc_cyc, last_acc_cyc, start_cyc;
  int clken_bad, max_lead, stall_obs, busy_seen, clken_seen;
  bit m_active = 1'b0;
  int m_rem, m_len, m_cur, m_issued, m_accepted;

  bram_stream_reader #(
    .ADDR_WIDTH (AW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .base_addr     (base_addr),
    .length        (length),
    .abort         (abort),
    .busy          (busy),
    .done          (done),
    .bram_clken    (bram_clken),
    .bram_addr     (bram_addr),
    .bram_we       (bram_we),
    .bram_data_out (bram_data_out),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .stall_cnt     (stall_cnt)
  );

  always #5 clk = ~clk;

  // BRAM model: data one cycle after the enabled read
  always @(posedge clk) if (bram_clken) bram_data_out <= mem[bram_addr];

  // Monitor + reference model, sampled mid-cycle
  always @(negedge clk) begin
    bit exp_clken;
    cyc++;
    exp_clken = 1'b0;
    if (!rst_n) begin
      m_active = 1'b0;
    end else begin
      if (!m_active && start) begin
        start_cyc = cyc;
        if (!abort && length != 0) begin
          m_active = 1'b1; m_rem = int'(length); m_len = int'(length);
          m_cur = int'(base_addr); m_issued = 0; m_accepted = 0;
        end
      end
      if (m_active)
        exp_clken = !abort && (m_rem > 0) && ((m_issued - m_accepted) < DEPTH);
      if (bram_clken && m_active) begin
        addrs.push_back(int'(bram_addr));
        m_cur = (m_cur + 1) % NWORD; m_rem--; m_issued++;
        if (m_issued - m_accepted > max_lead) max_lead = m_issued - m_accepted;
      end
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (out_valid && out_ready) begin
        got.push_back(out_data);
        if (first_acc_cyc < 0) first_acc_cyc = cyc;
        last_acc_cyc = cyc;
        if (m_active) m_accepted++;
      end
      if (out_valid && !out_ready) stall_obs++;
      if (m_active && abort) m_active = 1'b0;
      if (m_active && m_accepted == m_len) m_active = 1'b0;
    end
    if (bram_clken !== exp_clken) clken_bad++;
    if (bram_clken) clken_seen++;
    if (busy) busy_seen++;
    if (done) begin done_cnt++; done_cyc = cyc; end
  end

  task automatic clear_obs();
    got.delete(); addrs.delete();
    done_cnt = 0; done_cyc = -1; first_valid_cyc = -1; first_acc_cyc = -1;
    last_acc_cyc = -1; start_cyc = -1; clken_bad = 0; max_lead = 0;
    stall_obs = 0; busy_seen = 0; clken_seen = 0;
  endtask

  // Drive one burst. mode 0: ready high, 1: random ready + ignored starts,
  // 2: ready low for cycles 3..12. abort_at: abort on that accepted word (0 = none).
  task automatic run_burst(input int b, input int l, input int mode, input int abort_at);
    int k;
    bit fin;
    start = 1'b1; base_addr = AW'(b); length = (AW+1)'(l); abort = 1'b0;
    k = 0; fin = 1'b0;
    while (!fin) begin
      case (mode)
        1:       out_ready = ($urandom_range(0, 3) != 0);
        2:       out_ready = !(k >= 3 && k <= 12);
        default: out_ready = 1'b1;
      endcase
      abort = (abort_at != 0 && k > 0 && out_valid && out_ready && m_accepted == abort_at - 1);
      if (k > 0) begin
        if (mode == 1 && m_active && $urandom_range(0, 9) == 0) begin
          start = 1'b1; base_addr = AW'($urandom_range(0, NWORD - 1));
          length = (AW+1)'($urandom_range(1, 30));
        end else begin
          start = 1'b0;
        end
      end
      @(posedge clk); #1;
      k++;
      if (done_cnt > 0 || abort) fin = 1'b1;
      if (k > 600) begin
        checks++; errors++;
        $display("FAIL burst_timeout: cycles=%0d required done within 600", k);
        fin = 1'b1;
      end
    end
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, bram_clken, out_valid} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b required 0000", {busy, done, bram_clken, out_valid});
    end
    checks++;
    if (bram_addr !== '0 || out_data !== '0) begin
      errors++; $display("FAIL reset_addr_data: got addr=%h data=%h required 0", bram_addr, out_data);
    end
    checks++;
    if (stall_cnt !== 16'h0) begin
      errors++; $display("FAIL reset_stall: got %h required 0", stall_cnt);
    end
    checks++;
    if (bram_we !== 4'h0) begin
      errors++; $display("FAIL reset_we: got %h required 0", bram_we);
    end
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    clear_obs();
    run_burst(32'h010, 8, 0, 0);
    checks++;
    if (got.size() != 8) begin
      errors++; $display("FAIL basic_count: got %0d words required 8", got.size());
    end
    foreach (got[i]) begin
      checks++;
      if (got[i] !== mem[(16 + i) % NWORD]) begin
        errors++; $display("FAIL basic_word%0d: got %h required %h", i, got[i], mem[16 + i]);
      end
    end
    foreach (addrs[i]) begin
      checks++;
      if (addrs[i] != 16 + i) begin
        errors++; $display("FAIL basic_addr%0d: got %h required %h", i, addrs[i], 16 + i);
      end
    end
    checks++;
    if (first_valid_cyc - start_cyc != 2) begin
      errors++; $display("FAIL basic_latency: got %0d required 2", first_valid_cyc - start_cyc);
    end
    checks++;
    if (last_acc_cyc - first_acc_cyc != 7) begin
      errors++; $display("FAIL basic_throughput: got span %0d required 7", last_acc_cyc - first_acc_cyc);
    end
    checks++;
    if (done_cnt != 1 || done_cyc - last_acc_cyc < 1 || done_cyc - last_acc_cyc > 2) begin
      errors++;
      $display("FAIL basic_done: got count=%0d offset=%0d required count=1 offset 1..2",
               done_cnt, done_cyc - last_acc_cyc);
    end
    checks++;
    if (clken_bad != 0 || bram_we !== 4'h0) begin
      errors++; $display("FAIL basic_clken: got %0d bad cycles we=%h required 0", clken_bad, bram_we);
    end
  endtask

  task automatic test_wrap();
    int exp_a[4] = '{32'hFFE, 32'hFFF, 32'h000, 32'h001};
    clear_obs();
    run_burst(32'hFFE, 4, 0, 0);
    checks++;
    if (addrs.size() != 4) begin
      errors++; $display("FAIL wrap_reads: got %0d reads required 4", addrs.size());
    end
    foreach (addrs[i]) begin
      checks++;
      if (i < 4 && addrs[i] != exp_a[i]) begin
        errors++; $display("FAIL wrap_addr%0d: got %h required %h", i, addrs[i], exp_a[i]);
      end
    end
    foreach (got[i]) begin
      checks++;
      if (i < 4 && got[i] !== mem[exp_a[i]]) begin
        errors++; $display("FAIL wrap_word%0d: got %h required %h", i, got[i], mem[exp_a[i]]);
      end
    end
  endtask

  task automatic test_backpressure();
    int b, exp_stall;
    b = $urandom_range(0, NWORD - 1);
    clear_obs();
    run_burst(b, 16, 2, 0);
    checks++;
    if (got.size() != 16) begin
      errors++; $display("FAIL bp_count: got %0d words required 16", got.size());
    end
    foreach (got[i]) begin
      checks++;
      if (got[i] !== mem[(b + i) % NWORD]) begin
        errors++; $display("FAIL bp_word%0d: got %h required %h", i, got[i], mem[(b + i) % NWORD]);
      end
    end
    checks++;
    if (max_lead != DEPTH || clken_bad != 0) begin
      errors++;
      $display("FAIL bp_issue: got lead=%0d bad=%0d required lead=%0d bad=0", max_lead, clken_bad, DEPTH);
    end
`ifdef BRAM_STREAM_STALL_CNT_EN
    exp_stall = stall_obs;
`else
    exp_stall = 0;
`endif
    checks++;
    if (int'(stall_cnt) != exp_stall) begin
      errors++; $display("FAIL bp_stall_cnt: got %0d required %0d", stall_cnt, exp_stall);
    end
  endtask

  task automatic test_zero_len();
    clear_obs();
    run_burst($urandom_range(0, NWORD - 1), 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done_cnt != 1 || done_cyc - start_cyc != 1) begin
      errors++;
      $display("FAIL zero_done: got count=%0d offset=%0d required 1,1", done_cnt, done_cyc - start_cyc);
    end
    checks++;
    if (clken_seen != 0 || busy_seen != 0) begin
      errors++; $display("FAIL zero_idle: got clken=%0d busy=%0d required 0,0", clken_seen, busy_seen);
    end
  endtask

  task automatic test_abort();
    int b;
    b = $urandom_range(0, NWORD - 1);
    clear_obs();
    run_burst(b, 10, 0, 3);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL abort_next: got valid=%b busy=%b done=%b required 0,0,1", out_valid, busy, done);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done_cnt != 1 || got.size() != 3 || clken_bad != 0) begin
      errors++;
      $display("FAIL abort_summary: got done=%0d words=%0d bad=%0d required 1,3,0",
               done_cnt, got.size(), clken_bad);
    end
    foreach (got[i]) begin
      checks++;
      if (got[i] !== mem[(b + i) % NWORD]) begin
        errors++; $display("FAIL abort_word%0d: got %h required %h", i, got[i], mem[(b + i) % NWORD]);
      end
    end
    clear_obs();
    run_burst(32'h100, 2, 0, 0);
    checks++;
    if (got.size() != 2) begin
      errors++; $display("FAIL after_abort_count: got %0d required 2", got.size());
    end
    foreach (got[i]) begin
      checks++;
      if (got[i] !== mem[256 + i]) begin
        errors++; $display("FAIL after_abort_word%0d: got %h required %h", i, got[i], mem[256 + i]);
      end
    end
  endtask

  task automatic test_abort_idle();
    clear_obs();
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (done_cnt != 0 || busy_seen != 0) begin
      errors++; $display("FAIL abort_idle: got done=%0d busy=%0d required 0,0", done_cnt, busy_seen);
    end
    clear_obs();
    start = 1'b1; abort = 1'b1; base_addr = AW'(32'h020); length = (AW+1)'(5);
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done_cnt != 1 || clken_seen != 0 || busy_seen != 0) begin
      errors++;
      $display("FAIL abort_start: got done=%0d clken=%0d busy=%0d required 1,0,0",
               done_cnt, clken_seen, busy_seen);
    end
  endtask

  task automatic test_random();
    int b, l, exp_stall;
    for (int n = 0; n < 6; n++) begin
      b = $urandom_range(0, NWORD - 1);
      l = $urandom_range(1, 20);
      clear_obs();
      run_burst(b, l, 1, 0);
      checks++;
      if (got.size() != l || done_cnt != 1 || clken_bad != 0) begin
        errors++;
        $display("FAIL rand%0d_summary: got words=%0d done=%0d bad=%0d required %0d,1,0",
                 n, got.size(), done_cnt, clken_bad, l);
      end
      foreach (got[i]) begin
        checks++;
        if (got[i] !== mem[(b + i) % NWORD]) begin
          errors++;
          $display("FAIL rand%0d_word%0d: got %h required %h", n, i, got[i], mem[(b + i) % NWORD]);
        end
      end
`ifdef BRAM_STREAM_STALL_CNT_EN
      exp_stall = stall_obs;
`else
      exp_stall = 0;
`endif
      checks++;
      if (int'(stall_cnt) != exp_stall) begin
        errors++; $display("FAIL rand%0d_stall: got %0d required %0d", n, stall_cnt, exp_stall);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_obs();
    start = 1'b1; base_addr = AW'($urandom_range(0, NWORD - 1)); length = (AW+1)'(12);
    out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, bram_clken, out_valid} !== 4'b0 || bram_addr !== '0 ||
        out_data !== '0 || stall_cnt !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got flags=%b addr=%h data=%h stall=%h required all 0",
               {busy, done, bram_clken, out_valid}, bram_addr, out_data, stall_cnt);
    end
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done_cnt != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_mid_done: got done=%0d busy=%b required 0,0", done_cnt, busy);
    end
  endtask

  initial begin
    for (int i = 0; i < NWORD; i++) mem[i] = $urandom;
    clear_obs();
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_len();
    test_abort();
    test_abort_idle();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bram_stream_reader.md
BRAM_STREAM_READER -- requirements
Module: bram_stream_reader

Interface
REQ-001 Parameter ADDR_WIDTH, default 12, word-address width of the downstream 32-bit BRAM port.
REQ-002 Parameter FIFO_DEPTH, default 4, output buffer entries; power of two, at least 2.
REQ-003 clk  in  1  single clock for all logic and the BRAM port.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle request to begin a burst; sampled only in IDLE.
REQ-006 base_addr  in  ADDR_WIDTH  first word address, captured on an accepted start.
REQ-007 length  in  ADDR_WIDTH+1  number of words to read, captured on an accepted start.
REQ-008 abort  in  1  terminate the current burst.
REQ-009 busy  out  1  high in RUN and DRAIN.
REQ-010 done  out  1  one-cycle pulse when a burst completes or is aborted.
REQ-011 bram_clken  out  1  BRAM port clock enable; high only on cycles that issue a read.
REQ-012 bram_addr  out  ADDR_WIDTH  BRAM word address.
REQ-013 bram_we  out  4  byte write enables; constant 0.
REQ-014 bram_data_out  in  32  BRAM read data, valid one cycle after bram_clken (unregistered BRAM output).
REQ-015 out_data  out  32  stream word.
REQ-016 out_valid  out  1  out_data holds a valid word.
REQ-017 out_ready  in  1  consumer accepts the word when out_valid and out_ready are both high.
REQ-018 stall_cnt  out  16  count of back-pressure cycles (see Configuration).

Function
REQ-019 The FSM SHALL have states IDLE, RUN and DRAIN.
REQ-020 IDLE->RUN on start with length!=0; IDLE stays IDLE and pulses done on the next cycle on start with length==0.
REQ-021 In RUN, the block SHALL issue one read per cycle when (FIFO occupancy + reads in flight) < FIFO_DEPTH and words remaining > 0.
REQ-022 Each issued read SHALL drive bram_addr = current address, and the address SHALL then increment modulo 2^ADDR_WIDTH (4095 wraps to 0).
REQ-023 Read data SHALL be written into the FIFO exactly one cycle after its issue cycle; no read data is ever dropped.
REQ-024 RUN->DRAIN when the last read is issued; DRAIN->IDLE when the FIFO is empty, no read is in flight and the last word has been accepted; done SHALL pulse in that same transition cycle.
REQ-025 out_valid SHALL equal FIFO not empty, and out_data SHALL equal the FIFO head; simultaneous FIFO write and read SHALL be allowed at any occupancy, including full.
REQ-026 Throughput SHALL be one word per cycle with out_ready held high; first-word latency SHALL be 2 cycles from the accepted start to out_valid.
REQ-027 start SHALL be ignored while busy.
REQ-028 abort in RUN or DRAIN SHALL stop issuing reads, flush the FIFO, discard any in-flight return, go to IDLE next cycle and pulse done; abort in IDLE SHALL have no effect; abort together with start in IDLE SHALL abort the new burst (no read issued, done pulses).

Reset
REQ-029 While rst_n is low: state=IDLE, FIFO empty, busy=0, done=0, bram_clken=0, bram_addr=0, out_valid=0, out_data=0, stall_cnt=0.
REQ-030 Reset asserted mid-burst SHALL discard the burst without a done pulse.

Configuration
REQ-031 Macro BRAM_STREAM_STALL_CNT_EN: when defined, stall_cnt SHALL increment on every cycle with out_valid=1 and out_ready=0, saturate at 0xFFFF, and clear on each accepted start; when undefined, stall_cnt SHALL be constant 0 and no counter logic SHALL exist.

Structure
REQ-032 A shared package SHALL hold the FSM state enumeration and the default ADDR_WIDTH and FIFO_DEPTH constants.
REQ-033 The buffer SHALL be one sub-module, stream_fifo (synchronous FIFO with full, empty and occupancy outputs, FIFO_DEPTH entries by 32 bits).

Verification
REQ-034 base=0x010, length=8, out_ready=1 -> 8 words from addresses 0x010..0x017 in order, out_valid first high 2 cycles after start, done pulse after the 8th accept.
REQ-035 base=0xFFE, length=4 -> reads addresses 0xFFE, 0xFFF, 0x000, 0x001.
REQ-036 length=16, out_ready low for cycles 3..12 -> bram_clken stops once occupancy plus in-flight reaches 4, no word is lost or duplicated, and with the macro defined stall_cnt equals the number of stalled valid cycles.
REQ-037 length=0 -> no bram_clken, done pulses once, busy stays 0.
REQ-038 abort at the 3rd accepted word of length=10 -> out_valid low next cycle, IDLE, a single done pulse, and a following start with base=0x100, length=2 returns only 0x100 and 0x101 data.
REQ-039 rst_n low mid-burst -> all outputs at reset values immediately, no done pulse.
